// File: rtl/udc_pkg.sv
// Shared encodings for the up/down counter step controller.
package udc_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/udc_core.sv
// Counter register with load/clear/step; wrap is registered alongside the step.
module udc_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  import udc_pkg::*;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (ld) begin
        count <= ld_val;
      end else if (en) begin
        if (dir == DIR_DOWN) begin
          count <= count - 1'b1;
          wrap  <= (count == '0);
        end else begin
          count <= count + 1'b1;
          wrap  <= &count;
        end
      end
    end
  end

endmodule

// File: rtl/udc_step_controller.sv
// Command sequencer: accepts LOAD/CLEAR/UP-n/DOWN-n, steps the counter once per
// clock and reports completion with a one-cycle done pulse.
module udc_step_controller #(
  parameter int WIDTH = 4,
  parameter int STEPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);
  import udc_pkg::*;

  state_e           state, state_n;
  logic [STEPW-1:0] remaining, remaining_n;
  logic             dir_n, aborted_n;
  logic             en, ld, clr;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      dir       <= DIR_UP;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      dir       <= dir_n;
      aborted   <= aborted_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    dir_n       = dir;
    aborted_n   = 1'b0;
    en          = 1'b0;
    ld          = 1'b0;
    clr         = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              ld      = 1'b1;
              state_n = S_DONE;
            end
            OP_CLEAR: begin
              clr     = 1'b1;
              state_n = S_DONE;
            end
            default: begin
              dir_n = (cmd_op == OP_DOWN) ? DIR_DOWN : DIR_UP;
              if (cmd_steps == '0) begin
                state_n = S_DONE;
              end else begin
                remaining_n = cmd_steps;
                state_n     = S_RUN;
              end
            end
          endcase
        end
      end
      S_RUN: begin
        // abort beats the final step: no count change on that edge
        if (abort) begin
          aborted_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          en          = 1'b1;
          remaining_n = remaining - 1'b1;
          if (remaining == STEPW'(1)) state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  udc_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .dir    (dir),
    .ld     (ld),
    .ld_val (cmd_arg),
    .clr    (clr),
    .count  (count),
    .wrap   (wrap)
  );

endmodule

// File: tb/tb_udc_step_controller.sv
// Scoreboard bench: expected completions are queued at issue and popped on done.
module tb_udc_step_controller;
  import udc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [7:0] cmd_steps;
  logic       abort;
  logic [3:0] count;
  logic       dir, busy, done, aborted, wrap;

  typedef struct {
    logic [3:0] count;
    logic       aborted;
    int         wraps;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         wrap_cnt = 0;
  logic [3:0] m_count = 4'h0;

  always #5 clk = ~clk;

  udc_step_controller #(.WIDTH(4), .STEPW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .count     (count),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .wrap      (wrap)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // completion monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (wrap) wrap_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_count", int'(count), int'(e.count));
          chk("done_aborted", int'(aborted), int'(e.aborted));
          chk("done_wraps", wrap_cnt, e.wraps);
        end
        wrap_cnt = 0;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] arg, input logic [7:0] steps);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_steps = steps;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] op, input logic [3:0] arg);
    exp_t e;
    logic [3:0] v;
    v = (op == OP_CLEAR) ? 4'h0 : arg;
    e.count = v; e.aborted = 1'b0; e.wraps = 0;
    sb.push_back(e);
    send(op, arg, 8'd0);
    chk("load_count", int'(count), int'(v));
    chk("load_done", int'(done), 1);
    m_count = v;
  endtask

  // UP/DOWN with optional abort after abort_at steps (-1 = none)
  task automatic run_step(input logic down, input int n, input int abort_at);
    exp_t       e;
    logic [3:0] c;
    logic       w;
    int         taken, wraps;
    taken = (abort_at >= 0 && abort_at < n) ? abort_at : n;
    c = m_count; wraps = 0;
    for (int i = 0; i < taken; i++) begin
      if (down) begin wraps += (c == 4'h0) ? 1 : 0; c = c - 4'h1; end
      else      begin wraps += (c == 4'hF) ? 1 : 0; c = c + 4'h1; end
    end
    e.count = c; e.aborted = (taken < n); e.wraps = wraps;
    sb.push_back(e);
    send(down ? OP_DOWN : OP_UP, 4'h0, 8'(n));
    chk("dir", int'(dir), int'(down));
    if (n == 0) begin
      chk("zero_done", int'(done), 1);
      chk("zero_count", int'(count), int'(m_count));
      return;
    end
    chk("busy_start", int'(busy), 1);
    c = m_count;
    for (int i = 1; i <= taken; i++) begin
      w = down ? (c == 4'h0) : (c == 4'hF);
      c = down ? c - 4'h1 : c + 4'h1;
      @(posedge clk); #1;
      chk("step_count", int'(count), int'(c));
      chk("step_wrap", int'(wrap), int'(w));
      chk("step_busy", int'(busy), (i < n) ? 1 : 0);
    end
    if (taken < n) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_count", int'(count), int'(c));
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(aborted & done), 1);
      chk("abort_ready", int'(cmd_ready), 0);
      @(posedge clk); #1;
      chk("abort_ready_next", int'(cmd_ready), 1);
    end else begin
      chk("last_done", int'(done), 1);
    end
    m_count = c;
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'h0;
    cmd_steps = 8'd0; abort = 1'b0;
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrap", int'(wrap), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", int'(cmd_ready), 1);
    chk("busy_after_rst", int'(busy), 0);

    // 1: LOAD, done for exactly one cycle
    do_load(OP_LOAD, 4'h9);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);

    // 2: UP 3 from E, wrap on F->0
    do_load(OP_LOAD, 4'hE);
    run_step(1'b0, 3, -1);

    // 3: DOWN 2 from 1, wrap on 0->F
    do_load(OP_LOAD, 4'h1);
    run_step(1'b1, 2, -1);

    // 4: UP 10 from 0, abort after 3 steps
    do_load(OP_CLEAR, 4'h7);
    run_step(1'b0, 10, 3);

    // 5: zero-step command, then valid held high through RUN/DONE
    run_step(1'b1, 0, -1);
    do_load(OP_LOAD, 4'h4);
    e.count = 4'h6; e.aborted = 1'b0; e.wraps = 0; sb.push_back(e);
    e.count = 4'hB; e.aborted = 1'b0; e.wraps = 0; sb.push_back(e);
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_steps = 8'd2;
    @(posedge clk); #1;
    cmd_op = OP_LOAD; cmd_arg = 4'hB;          // stays valid, must wait for IDLE
    @(posedge clk); #1;
    chk("held_step1", int'(count), 5);
    chk("held_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("held_step2", int'(count), 6);
    chk("held_done_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("held_idle_count", int'(count), 6);
    chk("held_idle_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("held_load", int'(count), 11);
    m_count = 4'hB;

    // 6: reset mid-RUN
    do_load(OP_LOAD, 4'h2);
    e.count = 4'h0; e.aborted = 1'b0; e.wraps = 0; sb.push_back(e);
    send(OP_UP, 4'h0, 8'd10);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_count", int'(count), 5);
    rst = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_dir", int'(dir), 0);
    chk("arst_done", int'(done), 0);
    void'(sb.pop_back());
    wrap_cnt = 0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    m_count = 4'h0;
    do_load(OP_CLEAR, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
